// File: rtl/scan_frame_collector.sv
// -----------------------------------------------------------------------------
// scan_frame_collector
//
// Purpose:
//   Downstream collector for a pair of scanners. When a scanner has a full
//   buffer, the collector grants it. Two-way contention is resolved by a
//   round-robin bit. The collector requests a transfer and captures one
//   DEPTH-byte frame into a local buffer. It then holds that frame for the
//   CPU until cpu_ack. A capture aborts, with a sticky error, when the
//   selected source stays silent for TIMEOUT consecutive cycles.
//
// Optional feature (macro SCAN_CHECKSUM_EN):
//   When defined, a mod-256 sum of the captured bytes is presented on
//   checksum while the frame is held. When undefined, checksum is tied to
//   8'h00 and no accumulator exists.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   ready1/ready2      scanner has a full buffer ready to transfer
//   data1/data2        scanner byte streams
//   valid1/valid2      byte-valid qualifiers for data1/data2
//   transfer1/2        transfer request to the granted scanner
//   frame_valid        complete frame held for the CPU
//   frame_src          source of held frame (0 = scanner 1, 1 = scanner 2)
//   rd_addr/rd_data    CPU read port, 1-cycle registered latency
//   cpu_ack            CPU releases the held frame / clears error
//   checksum           mod-256 sum of the held frame
//   error              sticky capture-timeout flag
// -----------------------------------------------------------------------------
module scan_frame_collector #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ready1,
    input  logic          ready2,
    input  logic [7:0]    data1,
    input  logic [7:0]    data2,
    input  logic          valid1,
    input  logic          valid2,
    output logic          transfer1,
    output logic          transfer2,
    output logic          frame_valid,
    output logic          frame_src,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          cpu_ack,
    output logic [7:0]    checksum,
    output logic          error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t        state;
    logic          sel;
    logic          prio;
    logic [AW-1:0] count;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    buf_mem [DEPTH];

    // Selected-source stream and derived capture controls
    logic       valid_sel;
    logic [7:0] data_sel;
    logic       wr_en;
    logic       last_byte;
    logic       grant_any;
    logic       grant_sel;
    logic       timed_out;
    logic       addr_ok;

    assign valid_sel = sel ? valid2 : valid1;
    assign data_sel  = sel ? data2  : data1;
    assign wr_en     = (state == CAPTURE) && valid_sel && !rst;
    assign last_byte = (count == AW'(DEPTH - 1));
    assign timed_out = (idle_cnt == TW'(TIMEOUT - 1));

    // A lone ready wins outright; under contention the round-robin bit decides
    assign grant_any = ready1 | ready2;
    assign grant_sel = (ready1 && ready2) ? prio : ready2;

    // Out-of-range reads only exist when the address space exceeds the buffer
    generate
        if (DEPTH >= (2 ** AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (32'(rd_addr) < DEPTH);
        end
    endgenerate

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 1'b0;
            prio        <= 1'b0;
            count       <= '0;
            idle_cnt    <= '0;
            transfer1   <= 1'b0;
            transfer2   <= 1'b0;
            frame_valid <= 1'b0;
            frame_src   <= 1'b0;
            error       <= 1'b0;
        end else begin
            // cpu_ack clears the sticky error in every state; a timeout
            // abort below in the same cycle re-sets it.
            if (cpu_ack) begin
                error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel       <= grant_sel;
                        prio      <= ~prio;
                        transfer1 <= ~grant_sel;
                        transfer2 <= grant_sel;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    count    <= '0;
                    idle_cnt <= '0;
                    state    <= CAPTURE;
                end

                CAPTURE: begin
                    if (valid_sel) begin
                        // A byte always beats a coincident timeout
                        idle_cnt <= '0;
                        count    <= count + 1'b1;
                        if (last_byte) begin
                            transfer1   <= 1'b0;
                            transfer2   <= 1'b0;
                            frame_valid <= 1'b1;
                            frame_src   <= sel;
                            state       <= HOLD;
                        end
                    end else if (timed_out) begin
                        transfer1 <= 1'b0;
                        transfer2 <= 1'b0;
                        error     <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (cpu_ack) begin
                        frame_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Frame buffer write port; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[count] <= data_sel;
        end
    end

    // Registered read port; a same-cycle write returns the previous byte
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (addr_ok) begin
            rd_data <= buf_mem[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end

`ifdef SCAN_CHECKSUM_EN
    logic [7:0] acc;

    // Running sum restarts on every capture; the final byte is folded in
    // directly so checksum is valid in the same cycle as frame_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= 8'h00;
            checksum <= 8'h00;
        end else begin
            if (state == REQ) begin
                acc <= 8'h00;
            end else if (wr_en) begin
                acc <= acc + data_sel;
            end
            if (wr_en && last_byte) begin
                checksum <= acc + data_sel;
            end
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: doc/scan_frame_collector.md
Name: scan_frame_collector

Overview:
- Downstream consumer of the two-scanner pair. It arbitrates between the two scanners' ready-to-transfer flags and asserts the matching transfer request.
- It captures one DEPTH-byte frame from the granted scanner into a local frame buffer.
- It holds the frame for the CPU until acknowledged, optionally with a modular checksum.

Parameters:
- DEPTH, 16: bytes per frame; matches the scanner buffer depth.
- AW, 4: address width; must satisfy 2^AW >= DEPTH.
- TIMEOUT, 32: max cycles between consecutive valid bytes of the selected source before the capture aborts.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- ready1  input  1  scanner 1 has a full buffer ready to transfer.
- ready2  input  1  scanner 2 has a full buffer ready to transfer.
- data1  input  8  scanner 1 byte stream.
- data2  input  8  scanner 2 byte stream.
- valid1  input  1  data1 carries a valid byte this cycle.
- valid2  input  1  data2 carries a valid byte this cycle.
- transfer1  output  1  transfer request to scanner 1.
- transfer2  output  1  transfer request to scanner 2.
- frame_valid  output  1  complete frame held for CPU.
- frame_src  output  1  source of held frame (0 = scanner 1, 1 = scanner 2).
- rd_addr  input  AW  CPU read address.
- rd_data  output  8  frame byte; registered, 1-cycle latency.
- cpu_ack  input  1  CPU releases the held frame.
- checksum  output  8  mod-256 sum of held frame bytes.
- error  output  1  sticky timeout flag; cleared by rst or cpu_ack.

Behaviour:
- States: IDLE, REQ, CAPTURE, HOLD.
- Reset: synchronous, active-high, wins over all other events. State goes to IDLE. transfer1/2, frame_valid, frame_src, rd_data, checksum, error, byte count, timeout counter and priority bit all go to 0. Buffer contents are don't-care.
- IDLE:
  - If exactly one of ready1/ready2 is high, grant that source.
  - If both are high, grant per the round-robin priority bit (0 = scanner 1 first); the bit toggles after every grant.
  - On a grant, latch sel and go to REQ.
- REQ:
  - transfer_sel is asserted in the cycle after the grant and stays high through CAPTURE.
  - Go to CAPTURE immediately; the count and timeout counter are cleared.
  - Only one transfer output is ever high.
- CAPTURE:
  - Each cycle valid_sel=1, write data_sel to buf[count] and increment count. Bytes from the non-selected source are ignored.
  - Timeout counter: resets on each valid byte, otherwise increments. At TIMEOUT with count<DEPTH, drop transfer, set error=1, discard partial frame (frame_valid stays 0), go to IDLE.
  - When count reaches DEPTH-1 with valid high:
    - That is the final write.
    - Next cycle: transfer_sel=0, frame_valid=1, frame_src=sel, state HOLD.
  - Any valid bytes after DEPTH are ignored.
- HOLD:
  - The frame is held and both transfer outputs stay low.
  - ready flags are ignored and no new grant is made.
  - cpu_ack: frame_valid and error go to 0 the next cycle, state IDLE.
  - cpu_ack in any other state clears error only.
- Read port:
  - rd_data = buf[rd_addr] registered every cycle, independent of state.
  - rd_addr >= DEPTH returns 0.
  - A read of the address being written in the same cycle returns the old byte.
- Simultaneous events:
  - ready rising in the same cycle as cpu_ack is not granted until IDLE; grant occurs one cycle later.
  - Timeout and the final valid byte in the same cycle: the byte wins; the frame completes with no error.

Optional Feature:
- Macro: SCAN_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator clears on entry to CAPTURE and adds each written byte mod 256.
  - checksum is loaded when frame_valid rises and held through HOLD.
- Not defined: checksum is tied to 8'h00 and no accumulator logic is present.

Test Plan:
- ready1=1 only; valid1 high for 16 cycles with bytes 0x00..0x0F -> transfer1 high during capture, transfer2 never high; frame_valid=1, frame_src=0. Reading addrs 0..15 gives 0x00..0x0F one cycle after each rd_addr. checksum=0x78 with SCAN_CHECKSUM_EN, 0x00 without.
- ready1=ready2=1 at the same cycle after reset -> scanner 1 granted first. After cpu_ack, scanner 2 is granted next (frame_src=1) even though ready1 is still high.
- Capture from scanner 2; valid2 pulses for 5 bytes, then stays low for 32 cycles -> error=1, transfer2=0, frame_valid stays 0, state IDLE. Next cpu_ack clears error.
- valid1 gapped (one byte every 3 cycles, 16 bytes) -> frame completes with no error; garbage on data2/valid2 throughout is not stored.
- rst=1 asserted mid-capture at byte 7 -> next cycle all outputs 0. A subsequent ready1 restarts capture from buf[0].
- In HOLD, toggle ready2 and drive valid1 for 20 cycles -> buffer unchanged, no transfer asserted; cpu_ack returns to IDLE, then ready2 is granted.
